// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, special encodings and FSM states for the FP32 accumulator.
// Also holds the extended-mantissa helper used by the align stage.
package fp32_pkg;

  localparam int N    = 32;
  localparam int E    = 8;
  localparam int MA   = 23;
  localparam int BIAS = 127;

  localparam int SIGN   = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int M_HI   = 22;
  localparam int M_LO   = 0;

  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_e;

  // {hidden, fraction, G, R, S}; a zero exponent flushes the whole operand to zero.
  function automatic logic [26:0] ext27(input logic [31:0] w);
    return (w[EXP_HI:EXP_LO] == 8'd0) ? 27'd0 : {1'b1, w[M_HI:M_LO], 3'b000};
  endfunction

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter over a 28-bit magnitude; all-zero input yields 28.
module fp_lzc28 (
  input  logic [27:0] val,
  output logic [4:0]  lzc
);

  // Ascending scan so the most significant set bit is the last to write.
  always_comb begin
    lzc = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (val[i]) lzc = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_accum_n32.sv
// Sequential FP32 accumulator: one product per handshake, align/add/normalize/round
// with round-to-nearest-even, result and term count released on the last term.
module fp_accum_n32
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  state_e              state_q, state_d;
  logic [N-1:0]        op_q, op_d, acc_q, acc_d, spec_res_q, spec_res_d;
  logic                last_q, last_d, inf_q, inf_d, spec_q, spec_d;
  logic                sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [9:0]   exp_q, exp_d;
  logic [27:0]         man_q, man_d;
  logic [26:0]         sman_q, sman_d;

  logic [30:0]         a_mag, b_mag;
  logic [31:0]         l_w, s_w;
  logic [26:0]         s_ext, mask, sh_val;
  logic [7:0]          diff;
  logic [4:0]          lzc, lzc_m1;
  logic                inc;
  logic [24:0]         m25;
  logic signed [9:0]   rexp;

  fp_lzc28 u_lzc (.val(man_q), .lzc(lzc));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    inf_d       = inf_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    zero_d      = zero_q;
    exp_d       = exp_q;
    man_d       = man_q;
    sman_d      = sman_q;
    out_valid_d = out_valid_q;
    a_mag       = '0;
    b_mag       = '0;
    l_w         = '0;
    s_w         = '0;
    s_ext       = '0;
    mask        = '0;
    sh_val      = '0;
    diff        = '0;
    lzc_m1      = '0;
    inc         = 1'b0;
    m25         = '0;
    rexp        = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          last_d  = in_last;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        a_mag = (acc_q[EXP_HI:EXP_LO] == 8'd0) ? 31'd0 : acc_q[30:0];
        b_mag = (op_q[EXP_HI:EXP_LO] == 8'd0) ? 31'd0 : op_q[30:0];
        l_w   = (b_mag > a_mag) ? op_q : acc_q;
        s_w   = (b_mag > a_mag) ? acc_q : op_q;
        s_ext = ext27(s_w);
        diff  = l_w[EXP_HI:EXP_LO] - s_w[EXP_HI:EXP_LO];
        if (diff >= 8'd27) begin
          sh_val = {26'd0, |s_ext};
        end else begin
          mask   = (27'd1 << diff) - 27'd1;
          sh_val = (s_ext >> diff) | {26'd0, |(s_ext & mask)};
        end
        sign_d = l_w[SIGN];
        sub_d  = l_w[SIGN] ^ s_w[SIGN];
        exp_d  = signed'({2'b00, l_w[EXP_HI:EXP_LO]});
        man_d  = {1'b0, ext27(l_w)};
        sman_d = sh_val;
        // Infinities bypass the datapath; a sticky inf holds until the result is drained.
        spec_d = inf_q | (op_q[EXP_HI:EXP_LO] == EXP_INF);
        if (inf_q) begin
          spec_res_d = ((op_q[EXP_HI:EXP_LO] == EXP_INF) && (acc_q != QNAN) &&
                        (op_q[SIGN] != acc_q[SIGN])) ? QNAN : acc_q;
        end else begin
          spec_res_d = {op_q[SIGN], EXP_INF, 23'd0};
        end
        state_d = ADD;
      end

      ADD: begin
        man_d  = sub_q ? (man_q - {1'b0, sman_q}) : (man_q + {1'b0, sman_q});
        zero_d = (man_d == 28'd0);
        if (zero_d) sign_d = 1'b0;
        state_d = NORM;
      end

      NORM: begin
        if (!zero_q) begin
          if (man_q[27]) begin
            man_d = {1'b0, man_q[27:2], man_q[1] | man_q[0]};
            exp_d = exp_q + 10'sd1;
          end else begin
            lzc_m1 = lzc - 5'd1;
            man_d  = man_q << lzc_m1;
            exp_d  = exp_q - signed'({5'd0, lzc_m1});
          end
          if (exp_d <= 10'sd0) zero_d = 1'b1;
        end
        state_d = ROUND;
      end

      ROUND: begin
        inc  = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
        m25  = {1'b0, man_q[26:3]} + {24'd0, inc};
        rexp = m25[24] ? exp_q + 10'sd1 : exp_q;
        if (spec_q) begin
          acc_d = spec_res_q;
          inf_d = 1'b1;
        end else if (zero_q) begin
          acc_d = {sign_q, 31'd0};
        end else if (rexp >= 10'sd255) begin
          acc_d = {sign_q, EXP_INF, 23'd0};
          inf_d = 1'b1;
        end else begin
          acc_d = {sign_q, rexp[7:0], m25[24] ? m25[23:1] : m25[22:0]};
        end
        state_d = last_q ? DONE : IDLE;
      end

      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          inf_d       = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      spec_res_q  <= '0;
      last_q      <= 1'b0;
      inf_q       <= 1'b0;
      spec_q      <= 1'b0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      exp_q       <= '0;
      man_q       <= '0;
      sman_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      spec_res_q  <= spec_res_d;
      last_q      <= last_d;
      inf_q       <= inf_d;
      spec_q      <= spec_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      man_q       <= man_d;
      sman_q      <= sman_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_fp_accum_n32.sv
// Directed-vector bench for fp_accum_n32: sums, rounding, specials, backpressure, resets.
module tb_fp_accum_n32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fp_accum_n32 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [31:0] d, input logic last);
    int w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Drives a two-term accumulation and reports what the output showed when valid rose.
  task automatic acc2(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] d, output logic [15:0] c, output int lat);
    send(a, 1'b0);
    send(b, 1'b1);
    wait_out(lat);
    d = out_data;
    c = out_count;
    pop();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'd0 || out_count !== 16'd0) begin
      bad++;
      $display("FAIL reset: rdy/vld/busy=%b data=%h cnt=%0d required 100 00000000 0",
               {in_ready, out_valid, busy}, out_data, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    logic [31:0] d;
    logic [15:0] c;
    int          lat;
    acc2(32'h3F800000, 32'h40000000, d, c, lat);
    total++;
    if (d !== 32'h40400000) begin bad++; $display("FAIL add_1p2_data: got %h required 40400000", d); end
    total++;
    if (c !== 16'd2) begin bad++; $display("FAIL add_1p2_count: got %0d required 2", c); end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL add_1p2_latency: got %0d required 5", lat); end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 16'd0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL add_1p2_clear: vld=%b busy=%b cnt=%0d data=%h required 0 0 0 00000000",
               out_valid, busy, out_count, out_data);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] d;
    logic [15:0] c;
    int          lat;
    acc2(32'h3F800000, 32'hBF800000, d, c, lat);
    total++;
    if (d !== 32'h00000000) begin bad++; $display("FAIL cancel_data: got %h required 00000000", d); end
    total++;
    if (c !== 16'd2) begin bad++; $display("FAIL cancel_count: got %0d required 2", c); end
  endtask

  task automatic test_round();
    logic [31:0] d;
    logic [15:0] c;
    int          lat;
    acc2(32'h3F800000, 32'h33800000, d, c, lat);
    total++;
    if (d !== 32'h3F800000) begin bad++; $display("FAIL round_tie_even: got %h required 3F800000", d); end
    acc2(32'h3F800000, 32'h33C00000, d, c, lat);
    total++;
    if (d !== 32'h3F800001) begin bad++; $display("FAIL round_up: got %h required 3F800001", d); end
    acc2(32'h40000000, 32'h3F800000, d, c, lat);
    total++;
    if (d !== 32'h40400000) begin bad++; $display("FAIL order_2p1: got %h required 40400000", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [15:0] c;
    int          lat;
    acc2(32'h7F7FFFFF, 32'h7F7FFFFF, d, c, lat);
    total++;
    if (d !== 32'h7F800000) begin bad++; $display("FAIL overflow_inf: got %h required 7F800000", d); end
    acc2(32'h7F800000, 32'hFF800000, d, c, lat);
    total++;
    if (d !== 32'h7FC00000) begin bad++; $display("FAIL inf_minus_inf: got %h required 7FC00000", d); end
    acc2(32'hFF800000, 32'h3F800000, d, c, lat);
    total++;
    if (d !== 32'hFF800000) begin bad++; $display("FAIL sticky_neg_inf: got %h required FF800000", d); end
  endtask

  task automatic test_zero_terms();
    logic [31:0] d;
    logic [15:0] c;
    int          lat;
    send(32'h00000001, 1'b1);
    wait_out(lat);
    total++;
    if (out_data !== 32'd0 || out_count !== 16'd1) begin
      bad++;
      $display("FAIL denormal_single: data=%h cnt=%0d required 00000000 1", out_data, out_count);
    end
    pop();
    send(32'h80000000, 1'b1);
    wait_out(lat);
    total++;
    if (out_data !== 32'd0) begin bad++; $display("FAIL neg_zero_single: got %h required 00000000", out_data); end
    pop();
    acc2(32'h00400000, 32'hC0000000, d, c, lat);
    total++;
    if (d !== 32'hC0000000 || c !== 16'd2) begin
      bad++;
      $display("FAIL denormal_then_m2: data=%h cnt=%0d required C0000000 2", d, c);
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] hold_d;
    logic [15:0] hold_c;
    logic        ok = 1'b1;
    send(32'h3FC00000, 1'b1);
    wait_out(lat);
    hold_d = out_data;
    hold_c = out_count;
    total++;
    if (hold_d !== 32'h3FC00000 || hold_c !== 16'd1) begin
      bad++;
      $display("FAIL bp_result: data=%h cnt=%0d required 3FC00000 1", hold_d, hold_c);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== hold_d || out_count !== hold_c)
        ok = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_hold: vld=%b rdy=%b data=%h cnt=%0d required 1 0 3FC00000 1",
               out_valid, in_ready, out_data, out_count);
    end
    pop();
    send(32'h40A00000, 1'b1);
    wait_out(lat);
    total++;
    if (out_data !== 32'h40A00000 || out_count !== 16'd1) begin
      bad++;
      $display("FAIL bp_fresh_start: data=%h cnt=%0d required 40A00000 1", out_data, out_count);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40800000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b required 1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'd0 || out_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: rdy/vld/busy=%b data=%h cnt=%0d required 100 00000000 0",
               {in_ready, out_valid, busy}, out_data, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h40A00000, 1'b1);
    wait_out(lat);
    total++;
    if (out_data !== 32'h40A00000 || out_count !== 16'd1 || lat !== 5) begin
      bad++;
      $display("FAIL post_reset_single: data=%h cnt=%0d lat=%0d required 40A00000 1 5",
               out_data, out_count, lat);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_cancel();
    test_round();
    test_overflow();
    test_zero_terms();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
